serial_addsub: RTL and testbench



---
 rtl/serial_addsub.sv | 135 +++++++++++++
 tb/tb_serial_addsub.sv | 159 +++++++++++++++
 2 files changed

// File: rtl/serial_addsub.sv
// Bit-serial adder/subtractor: one result bit per clock, LSB first, with
// registered result, carry, signed overflow and zero flags.
module serial_addsub #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             c_out,
  output logic             overflow,
  output logic             zero
);

  localparam int CNT_W = $clog2(WIDTH) + 1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  function automatic logic majority(input logic x, input logic y, input logic z);
    return (x & y) | (x & z) | (y & z);
  endfunction

  state_t             state_r;
  logic [WIDTH-1:0]   a_sr_r;
  logic [WIDTH-1:0]   b_sr_r;
  logic [WIDTH-1:0]   acc_r;
  logic               carry_r;
  logic [CNT_W-1:0]   cnt_r;
  logic               busy_r;
  logic               done_r;
  logic [WIDTH-1:0]   result_r;
  logic               c_out_r;
  logic               overflow_r;
  logic               zero_r;

  logic               sum_bit_s;
  logic               carry_nxt_s;
  logic               cin_msb_s;
  logic [WIDTH-1:0]   acc_nxt_s;
  logic               last_bit_s;
  logic               accept_s;

  // Full-adder slice on the current LSBs and operand-acceptance decode.
  always_comb begin
    sum_bit_s   = a_sr_r[0] ^ b_sr_r[0] ^ carry_r;
    carry_nxt_s = majority(a_sr_r[0], b_sr_r[0], carry_r);
    cin_msb_s   = carry_r;
    acc_nxt_s   = {sum_bit_s, acc_r[WIDTH-1:1]};
    last_bit_s  = (cnt_r == CNT_W'(WIDTH - 1));
    if (start && ((state_r == ST_IDLE) || (state_r == ST_DONE))) begin
      accept_s = 1'b1;
    end else begin
      accept_s = 1'b0;
    end
  end

  // Control FSM, operand/accumulator shifting and output register update.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r    <= ST_IDLE;
      a_sr_r     <= {WIDTH{1'b0}};
      b_sr_r     <= {WIDTH{1'b0}};
      acc_r      <= {WIDTH{1'b0}};
      carry_r    <= 1'b0;
      cnt_r      <= {CNT_W{1'b0}};
      busy_r     <= 1'b0;
      done_r     <= 1'b0;
      result_r   <= {WIDTH{1'b0}};
      c_out_r    <= 1'b0;
      overflow_r <= 1'b0;
      zero_r     <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE, ST_DONE: begin
          done_r <= 1'b0;
          if (accept_s) begin
            // Subtraction is a + ~b + 1: invert b here, seed the carry with sub.
            a_sr_r  <= a;
            b_sr_r  <= b ^ {WIDTH{sub}};
            carry_r <= sub;
            acc_r   <= {WIDTH{1'b0}};
            cnt_r   <= {CNT_W{1'b0}};
            busy_r  <= 1'b1;
            state_r <= ST_RUN;
          end else begin
            busy_r  <= 1'b0;
            state_r <= ST_IDLE;
          end
        end
        ST_RUN: begin
          a_sr_r  <= {1'b0, a_sr_r[WIDTH-1:1]};
          b_sr_r  <= {1'b0, b_sr_r[WIDTH-1:1]};
          acc_r   <= acc_nxt_s;
          carry_r <= carry_nxt_s;
          cnt_r   <= cnt_r + CNT_W'(1);
          if (last_bit_s) begin
            busy_r     <= 1'b0;
            done_r     <= 1'b1;
            result_r   <= acc_nxt_s;
            c_out_r    <= carry_nxt_s;
            overflow_r <= cin_msb_s ^ carry_nxt_s;
            zero_r     <= (acc_nxt_s == {WIDTH{1'b0}});
            state_r    <= ST_DONE;
          end else begin
            busy_r     <= 1'b1;
            done_r     <= 1'b0;
            state_r    <= ST_RUN;
          end
        end
        default: begin
          busy_r  <= 1'b0;
          done_r  <= 1'b0;
          state_r <= ST_IDLE;
        end
      endcase
    end
  end

  assign busy     = busy_r;
  assign done     = done_r;
  assign result   = result_r;
  assign c_out    = c_out_r;
  assign overflow = overflow_r;
  assign zero     = zero_r;

endmodule

// File: tb/tb_serial_addsub.sv
// Directed scoreboard bench for serial_addsub at WIDTH=8.
module tb_serial_addsub;
  localparam int W = 8;

  logic         clk = 1'b0;
  logic         reset;
  logic         start;
  logic         sub;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         busy;
  logic         done;
  logic [W-1:0] result;
  logic         c_out;
  logic         overflow;
  logic         zero;

  typedef struct packed {
    logic [W-1:0] res;
    logic         c;
    logic         v;
    logic         z;
  } exp_t;

  exp_t         sb_q[$];
  logic [W-1:0] last_res;
  int           n_cmp = 0;
  int           n_err = 0;

  serial_addsub #(.WIDTH(W)) dut (
    .clk(clk), .reset(reset), .start(start), .sub(sub), .a(a), .b(b),
    .busy(busy), .done(done), .result(result), .c_out(c_out),
    .overflow(overflow), .zero(zero)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic exp_t model(input logic [W-1:0] x, input logic [W-1:0] y, input logic s);
    exp_t         e;
    logic [W:0]   sum;
    logic [W-1:0] yy;
    yy    = s ? ~y : y;
    sum   = {1'b0, x} + {1'b0, yy} + {{W{1'b0}}, s};
    e.res = sum[W-1:0];
    e.c   = sum[W];
    if (s) e.v = (x[W-1] != y[W-1]) && (e.res[W-1] != x[W-1]);
    else   e.v = (x[W-1] == y[W-1]) && (e.res[W-1] != x[W-1]);
    e.z   = (e.res == {W{1'b0}});
    return e;
  endfunction

  // Called at a negedge; returns at the negedge after E0.
  task automatic issue(input logic [W-1:0] x, input logic [W-1:0] y, input logic s);
    a = x; b = y; sub = s; start = 1'b1;
    sb_q.push_back(model(x, y, s));
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    a = W'($urandom); b = W'($urandom); sub = 1'($urandom);
    chk("busy_after_start", 32'(busy), 32'd1);
    chk("done_after_start", 32'(done), 32'd0);
  endtask

  // Walks E1..E_W; done must appear exactly at E_W. Optional start pulse at E_inj.
  task automatic wait_done(input string tag, input int inj);
    exp_t e;
    for (int k = 1; k <= W; k++) begin
      @(posedge clk);
      @(negedge clk);
      if (k == inj - 1) begin
        start = 1'b1; a = W'($urandom); b = W'($urandom); sub = 1'($urandom);
      end else begin
        start = 1'b0;
      end
      if (k < W) begin
        chk({tag, "_done_low"}, 32'(done), 32'd0);
        chk({tag, "_busy_high"}, 32'(busy), 32'd1);
        chk({tag, "_result_hold"}, 32'(result), 32'(last_res));
      end else begin
        chk({tag, "_done_at_E8"}, 32'(done), 32'd1);
        chk({tag, "_busy_at_E8"}, 32'(busy), 32'd0);
        n_cmp++;
        assert (sb_q.size() > 0) else begin
          n_err++;
          $error("FAIL %s_scoreboard: observed empty queue expected entry", tag);
        end
        if (sb_q.size() > 0) begin
          e = sb_q.pop_front();
          chk({tag, "_result"}, 32'(result), 32'(e.res));
          chk({tag, "_c_out"}, 32'(c_out), 32'(e.c));
          chk({tag, "_overflow"}, 32'(overflow), 32'(e.v));
          chk({tag, "_zero"}, 32'(zero), 32'(e.z));
          last_res = e.res;
        end
      end
    end
  endtask

  task automatic chk_cleared(input string tag);
    chk({tag, "_busy"}, 32'(busy), 32'd0);
    chk({tag, "_done"}, 32'(done), 32'd0);
    chk({tag, "_result"}, 32'(result), 32'd0);
    chk({tag, "_c_out"}, 32'(c_out), 32'd0);
    chk({tag, "_overflow"}, 32'(overflow), 32'd0);
    chk({tag, "_zero"}, 32'(zero), 32'd0);
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; sub = 1'b0; a = '0; b = '0;
    last_res = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk_cleared("reset");
    reset = 1'b0;

    issue(8'h0F, 8'h01, 1'b0); wait_done("add", 0);
    issue(8'hFF, 8'h01, 1'b0); wait_done("add_wrap", 0);
    issue(8'h05, 8'h07, 1'b1); wait_done("sub_borrow", 0);
    issue(8'h80, 8'h01, 1'b1); wait_done("sub_ovf", 0);
    issue(8'h7F, 8'h01, 1'b0); wait_done("add_ovf", 0);

    // Start pulse at E3 is ignored; start during done launches a back-to-back op.
    issue(8'h12, 8'h34, 1'b0); wait_done("ignore_e3", 3);
    issue(8'hA0, 8'h0B, 1'b1); wait_done("back2back", 0);
    issue(8'h00, 8'h00, 1'b1); wait_done("sub_zero", 0);

    // Abort mid-operation: reset sampled at E4.
    issue(8'h55, 8'h22, 1'b0);
    repeat (3) begin
      @(posedge clk);
      @(negedge clk);
    end
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk_cleared("mid_reset");
    reset = 1'b0;
    sb_q.delete();
    last_res = '0;
    for (int k = 0; k < 12; k++) begin
      @(posedge clk);
      @(negedge clk);
      chk("no_done_after_abort", 32'(done), 32'd0);
    end
    issue(8'h03, 8'h04, 1'b0); wait_done("post_reset", 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
